// File: rtl/mem_access_unit.sv
// Load/store unit: one-entry request buffer, SRAM-like request/response port, in-order pending FIFO.
// Latency: SRAM request from the cycle after acceptance; response in the same cycle as sram_data_ok.
// Backpressure: req_ready only while the buffer is empty; SRAM request held until the pending FIFO has room.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   req_*                  pipeline request (op = {we, unsigned, size[1:0]}), valid/ready handshake
//   sram_*                 SRAM-like request (held until sram_addr_ok) and data return (sram_data_ok)
//   resp_*                 one-cycle response pulse with aligned and extended load data
//   ale_valid, ale_addr    one-cycle misaligned-access pulse
//   proto_err              sticky: data returned with nothing outstanding
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [4:0]          req_rd,
    output logic                sram_req,
    output logic                sram_wr,
    output logic [1:0]          sram_size,
    output logic [31:0]         sram_addr,
    output logic [DATA_W/8-1:0] sram_wstrb,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic                sram_addr_ok,
    input  logic                sram_data_ok,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [4:0]          resp_rd,
    output logic                resp_is_ld,
    output logic                ale_valid,
    output logic [31:0]         ale_addr,
    output logic                proto_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    // What the response path needs to remember about an issued access.
    typedef struct packed {
        logic             is_ld;
        logic             uns;
        logic [1:0]       size;
        logic [OFF_W-1:0] off;
        logic [4:0]       rd;
    } pend_t;

    // Request buffer
    logic              buf_vld;
    logic [3:0]        buf_op;
    logic [31:0]       buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic [4:0]        buf_rd;

    // Pending FIFO
    pend_t             pend_mem [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              mis;
    logic              issue;
    logic              pop;
    pend_t             head;
    pend_t             new_ent;
    logic [DATA_W-1:0] lane;
    logic [OFF_W-1:0]  buf_off;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) return '0;
        return p + PTR_W'(1);
    endfunction

    // No bypass: a new request is taken only when the buffer is already empty.
    assign req_ready = !buf_vld && !reset;
    assign accept    = req_valid && req_ready;
    assign mis       = misaligned(req_op[1:0], req_addr[2:0]);

    assign sram_req  = buf_vld && (cnt < MAX_CNT);
    assign issue     = sram_req && sram_addr_ok;
    assign pop       = sram_data_ok && (cnt != '0);

    assign sram_wr   = buf_op[3];
    assign sram_size = buf_op[1:0];
    assign sram_addr = buf_addr;
    assign buf_off   = buf_addr[OFF_W-1:0];

    always_comb begin
        sram_wstrb = '0;
        if (buf_op[3]) begin
            case (buf_op[1:0])
                2'd0:    sram_wstrb = NB'(1) << buf_off;
                2'd1:    sram_wstrb = NB'(3) << buf_off;
                2'd2:    sram_wstrb = NB'(15) << buf_off;
                default: sram_wstrb = '1;
            endcase
        end
    end

    // Replicating the store data means the SRAM sees it on whichever lane the strobes select.
    always_comb begin
        sram_wdata = buf_wdata;
        case (buf_op[1:0])
            2'd0:    sram_wdata = {NB{buf_wdata[7:0]}};
            2'd1:    sram_wdata = {(NB / 2){buf_wdata[15:0]}};
            2'd2:    sram_wdata = {(DATA_W / 32){buf_wdata[31:0]}};
            default: sram_wdata = buf_wdata;
        endcase
    end

    assign new_ent = '{is_ld: !buf_op[3], uns: buf_op[2], size: buf_op[1:0],
                       off: buf_off, rd: buf_rd};

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld   <= 1'b0;
            buf_op    <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            buf_rd    <= '0;
            ale_valid <= 1'b0;
            ale_addr  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            proto_err <= 1'b0;
        end else begin
            ale_valid <= accept && mis;
            if (accept) ale_addr <= req_addr;

            if (accept && !mis) begin
                buf_vld   <= 1'b1;
                buf_op    <= req_op;
                buf_addr  <= req_addr;
                buf_wdata <= req_wdata;
                buf_rd    <= req_rd;
            end else if (issue) begin
                buf_vld <= 1'b0;
            end

            if (issue) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({issue, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase

            if (sram_data_ok && (cnt == '0)) proto_err <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while the count says they are live.
    always_ff @(posedge clk) begin
        if (issue) pend_mem[wr_ptr] <= new_ent;
    end

    assign head       = pend_mem[rd_ptr];
    assign lane       = sram_rdata >> {head.off, 3'b000};
    assign resp_valid = pop;
    assign resp_rd    = head.rd;
    assign resp_is_ld = head.is_ld;

    always_comb begin
        resp_rdata = '0;
        if (head.is_ld) begin
            case (head.size)
                2'd0: resp_rdata = head.uns ? DATA_W'(lane[7:0])  : DATA_W'($signed(lane[7:0]));
                2'd1: resp_rdata = head.uns ? DATA_W'(lane[15:0]) : DATA_W'($signed(lane[15:0]));
                2'd2: resp_rdata = head.uns ? DATA_W'(lane[31:0]) : DATA_W'($signed(lane[31:0]));
                default: resp_rdata = lane;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32-bit/MAX_OUT=2 instance driven from a vector table with an SRAM
// responder and response scoreboard, plus a 64-bit/MAX_OUT=1 instance driven by hand.
// Corner sequences: outstanding limit, reset mid-flight, stray data_ok.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 32-bit instance
    logic        req_valid, req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic        resp_valid, resp_is_ld, ale_valid, proto_err;
    logic [31:0] resp_rdata, ale_addr;
    logic [4:0]  resp_rd;

    // 64-bit instance
    logic        req_valid64, req_ready64;
    logic [3:0]  req_op64;
    logic [31:0] req_addr64;
    logic [63:0] req_wdata64;
    logic [4:0]  req_rd64;
    logic        sram_req64, sram_wr64;
    logic [1:0]  sram_size64;
    logic [31:0] sram_addr64;
    logic [7:0]  sram_wstrb64;
    logic [63:0] sram_wdata64;
    logic        addr_ok64, data_ok64;
    logic [63:0] rdata64;
    logic        resp_valid64, resp_is_ld64, ale_valid64, proto_err64;
    logic [63:0] resp_rdata64;
    logic [31:0] ale_addr64;
    logic [4:0]  resp_rd64;

    mem_access_unit #(.DATA_W(32), .MAX_OUT(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_addr(sram_addr),
        .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_is_ld(resp_is_ld),
        .ale_valid(ale_valid), .ale_addr(ale_addr), .proto_err(proto_err)
    );

    mem_access_unit #(.DATA_W(64), .MAX_OUT(1)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_op(req_op64), .req_addr(req_addr64),
        .req_wdata(req_wdata64), .req_rd(req_rd64),
        .sram_req(sram_req64), .sram_wr(sram_wr64), .sram_size(sram_size64), .sram_addr(sram_addr64),
        .sram_wstrb(sram_wstrb64), .sram_wdata(sram_wdata64),
        .sram_addr_ok(addr_ok64), .sram_data_ok(data_ok64), .sram_rdata(rdata64),
        .resp_valid(resp_valid64), .resp_rdata(resp_rdata64), .resp_rd(resp_rd64), .resp_is_ld(resp_is_ld64),
        .ale_valid(ale_valid64), .ale_addr(ale_addr64), .proto_err(proto_err64)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;      // what the SRAM returns
        logic [3:0]  strb;       // expected strobes
        logic [31:0] exp_wdata;  // expected sram_wdata
        logic [31:0] exp_rdata;  // expected resp_rdata
        bit          ale;        // expected misalignment
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } iss_t;

    typedef struct {
        logic [4:0]  rd;
        bit          is_ld;
        logic [31:0] rdata;
    } sb_t;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } infl_t;

    iss_t        iss_q[$];
    sb_t         sb_q[$];
    logic [31:0] ale_q[$];
    infl_t       infl[$];
    int          iss_log[$];
    int          rsp_log[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat    = 1;
    bit inject = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // SRAM responder + monitor. Decide and drive at the falling edge, sample 2 ns later.
    always @(negedge clk) begin
        iss_t  e;
        infl_t t;
        sb_t   s;
        logic [31:0] a;
        cyc++;
        sram_data_ok = 1'b0;
        if (!reset && sram_req && sram_addr_ok) begin
            if (iss_q.size() == 0) begin
                fail_now("unexpected_sram_req");
            end else begin
                e = iss_q.pop_front();
                chk("iss_addr", sram_addr, e.addr);
                chk("iss_wr", sram_wr, e.wr);
                chk("iss_size", sram_size, e.size);
                chk("iss_wstrb", sram_wstrb, e.strb);
                chk("iss_wdata", sram_wdata, e.wdata);
                infl.push_back('{e.rdata, cyc + lat});
                iss_log.push_back(cyc);
            end
        end
        if (!reset && infl.size() > 0 && infl[0].due <= cyc) begin
            t = infl.pop_front();
            sram_data_ok = 1'b1;
            sram_rdata   = t.rdata;
        end else if (!reset && inject) begin
            inject       = 0;
            sram_data_ok = 1'b1;
            sram_rdata   = 32'hA5A5_A5A5;
        end
        #2;
        if (!reset && resp_valid) begin
            if (sb_q.size() == 0) begin
                fail_now("unexpected_resp_valid");
            end else begin
                s = sb_q.pop_front();
                chk("resp_rd", resp_rd, s.rd);
                chk("resp_is_ld", resp_is_ld, s.is_ld);
                chk("resp_rdata", resp_rdata, s.rdata);
                rsp_log.push_back(cyc);
            end
        end
        if (!reset && ale_valid) begin
            if (ale_q.size() == 0) begin
                fail_now("unexpected_ale_valid");
            end else begin
                a = ale_q.pop_front();
                chk("ale_addr", ale_addr, a);
            end
        end
    end

    // Called just after a rising edge; returns just after the rising edge that accepted.
    task automatic send(input vec_t v, input logic [4:0] rd);
        bit acc = 0;
        int n = 0;
        if (v.ale) ale_q.push_back(v.addr);
        else begin
            iss_q.push_back('{v.addr, v.op[3], v.op[1:0], v.strb, v.exp_wdata, v.rdata});
            sb_q.push_back('{rd, !v.op[3], v.exp_rdata});
        end
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = rd;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) fail_now("send_timeout");
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() + iss_q.size() + ale_q.size()) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        sb_q.delete();
        iss_q.delete();
        ale_q.delete();
        wait_cycles(n);
        reset = 1'b0;
    endtask

    task automatic do64(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [7:0] strb,
                        input logic [63:0] exp_wd, input logic [63:0] exp_rd);
        req_valid64 = 1'b1;
        req_op64    = op;
        req_addr64  = addr;
        req_wdata64 = wdata;
        req_rd64    = 5'd7;
        @(negedge clk);
        chk("ready64", req_ready64, 1'b1);
        @(posedge clk);
        #1;
        req_valid64 = 1'b0;
        @(negedge clk);
        chk("sram_req64", sram_req64, 1'b1);
        chk("sram_addr64", sram_addr64, addr);
        chk("sram_wstrb64", sram_wstrb64, strb);
        chk("sram_wdata64", sram_wdata64, exp_wd);
        addr_ok64 = 1'b1;
        @(posedge clk);
        #1;
        addr_ok64 = 1'b0;
        data_ok64 = 1'b1;
        rdata64   = rdata;
        @(negedge clk);
        chk("resp_valid64", resp_valid64, 1'b1);
        chk("resp_rdata64", resp_rdata64, exp_rd);
        chk("resp_is_ld64", resp_is_ld64, !op[3]);
        chk("resp_rd64", resp_rd64, 5'd7);
        @(posedge clk);
        #1;
        data_ok64 = 1'b0;
    endtask

    vec_t tbl[13];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int n;
        //           op       addr          wdata         rdata          strb     exp_wdata     exp_rdata    ale
        tbl[0]  = '{4'b0000, 32'h1003, 32'h0,         32'h80FF_0000, 4'b0000, 32'h0,         32'hFFFF_FF80, 0}; // ld.b
        tbl[1]  = '{4'b1001, 32'h2002, 32'h1234,      32'h0,         4'b1100, 32'h1234_1234, 32'h0,         0}; // st.h
        tbl[2]  = '{4'b0010, 32'h3001, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         1}; // ld.w misaligned
        tbl[3]  = '{4'b0100, 32'h1001, 32'h0,         32'h0000_8500, 4'b0000, 32'h0,         32'h0000_0085, 0}; // ld.bu
        tbl[4]  = '{4'b0001, 32'h1002, 32'h0,         32'h8001_0000, 4'b0000, 32'h0,         32'hFFFF_8001, 0}; // ld.h
        tbl[5]  = '{4'b0101, 32'h1000, 32'h0,         32'h1234_F00D, 4'b0000, 32'h0,         32'h0000_F00D, 0}; // ld.hu
        tbl[6]  = '{4'b0010, 32'h1004, 32'h0,         32'hDEAD_BEEF, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0}; // ld.w
        tbl[7]  = '{4'b1000, 32'h2001, 32'hAB,        32'h0,         4'b0010, 32'hABAB_ABAB, 32'h0,         0}; // st.b
        tbl[8]  = '{4'b1010, 32'h2004, 32'hCAFE_F00D, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0,         0}; // st.w
        tbl[9]  = '{4'b0001, 32'h1001, 32'h0,         32'h0,         4'b0000, 32'h0,         32'h0,         1}; // ld.h misaligned
        tbl[10] = '{4'b1001, 32'h2003, 32'h5555,      32'h0,         4'b0000, 32'h0,         32'h0,         1}; // st.h misaligned
        tbl[11] = '{4'b1000, 32'h2000, 32'h1FF,       32'h0,         4'b0001, 32'hFFFF_FFFF, 32'h0,         0}; // st.b upper bits ignored
        tbl[12] = '{4'b0000, 32'h1000, 32'h0,         32'h0000_007F, 4'b0000, 32'h0,         32'h0000_007F, 0}; // ld.b positive

        req_valid = 0; req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        sram_addr_ok = 1'b1; sram_data_ok = 1'b0; sram_rdata = '0;
        req_valid64 = 0; req_op64 = '0; req_addr64 = '0; req_wdata64 = '0; req_rd64 = '0;
        addr_ok64 = 0; data_ok64 = 0; rdata64 = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_during_reset", req_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1'b1);
        chk("sram_req_after_reset", sram_req, 1'b0);
        chk("resp_valid_after_reset", resp_valid, 1'b0);
        chk("ale_valid_after_reset", ale_valid, 1'b0);
        chk("proto_err_after_reset", proto_err, 1'b0);
        @(posedge clk);
        #1;

        // Table-driven single accesses, back-to-back
        lat = 1;
        for (int i = 0; i < 13; i++) send(tbl[i], 5'(i + 1));
        drain();

        // Outstanding limit: third request waits for the first data_ok, responses in order
        lat = 5;
        iss_log.delete();
        rsp_log.delete();
        for (int i = 0; i < 3; i++) begin
            v = '{4'b0010, 32'h1010 + 32'(4 * i), 32'h0, 32'h1111_1111 * 32'(i + 1), 4'b0000, 32'h0,
                  32'h1111_1111 * 32'(i + 1), 0};
            send(v, 5'(20 + i));
        end
        drain();
        if (iss_log.size() == 3 && rsp_log.size() == 3) begin
            chk("second_issued_before_first_resp", iss_log[1] < rsp_log[0], 1'b1);
            chk("third_issue_after_first_resp", iss_log[2], 64'(rsp_log[0] + 1));
        end else begin
            fail_now("max_out_log_size");
        end

        // 64-bit datapath
        do64(4'b0101, 32'h0000_1006, 64'h0, 64'hBEEF_0000_0000_0000, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF);
        do64(4'b0010, 32'h0000_1004, 64'h0, 64'h8000_0001_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0001);
        do64(4'b1011, 32'h0000_1008, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
        do64(4'b1001, 32'h0000_100E, 64'hA55A, 64'h0, 8'hC0, 64'hA55A_A55A_A55A_A55A, 64'h0);
        do64(4'b0011, 32'h0000_1000, 64'h0, 64'hFEDC_BA98_7654_3210, 8'h00, 64'h0, 64'hFEDC_BA98_7654_3210);

        // Reset while a load is outstanding: its late data_ok is a protocol error
        lat = 8;
        v = '{4'b0010, 32'h1020, 32'h0, 32'h7777_7777, 4'b0000, 32'h0, 32'h7777_7777, 0};
        send(v, 5'd9);
        n = 0;
        while (iss_q.size() != 0 && n < 50) begin
            wait_cycles(1);
            n++;
        end
        if (n >= 50) fail_now("issue_timeout");
        pulse_reset(2);
        @(negedge clk);
        chk("proto_err_clear_after_reset", proto_err, 1'b0);
        wait_cycles(12);
        chk("proto_err_late_data_ok", proto_err, 1'b1);
        chk("late_data_ok_delivered", infl.size(), 0);

        // Stray data_ok after reset with nothing outstanding
        lat = 1;
        pulse_reset(2);
        @(negedge clk);
        chk("proto_err_cleared", proto_err, 1'b0);
        @(posedge clk);
        #1;
        inject = 1;
        @(negedge clk);
        #3;
        chk("stray_data_ok_no_resp", resp_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("proto_err_set", proto_err, 1'b1);
        wait_cycles(3);
        chk("proto_err_sticky", proto_err, 1'b1);

        chk("queues_empty", 64'(sb_q.size() + iss_q.size() + ale_q.size() + infl.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
